// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/forward controls out.
// master drives the status side, slave is the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  mem_reg_write;
    logic                  wb_reg_write;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_bubble;
    logic                  ex_mem_write;
    logic                  mem_wb_write;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
        output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        output mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
        input  ex_mem_write, mem_wb_write, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
        input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        input  mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
        output ex_mem_write, mem_wb_write, fwd_a, fwd_b,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: multi-bubble load-use stalls, branch flush,
// memory freeze, EX forwarding selects and saturating perf counters.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_unit_if.slave hz
);

    typedef enum logic {
        RUN,
        LU_STALL
    } state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_USE_STALLS - 1);
    localparam bit MULTI_BUBBLE = (LOAD_USE_STALLS > 1);

    state_t           state;
    logic [2:0]       lu_left;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic mem_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign rs1_hit   = hz.id_uses_rs1 & (hz.ex_rd == hz.id_rs1);
    assign rs2_hit   = hz.id_uses_rs2 & (hz.ex_rd == hz.id_rs2);
    assign load_use  = hz.ex_mem_read & (hz.ex_rd != '0)
                     & (rs1_hit | rs2_hit);

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && m_rd != '0 && m_rd == rs)
            sel = 2'b10;
        else if (w_we && w_rd != '0 && w_rd == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign hz.fwd_a = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write,
                              hz.wb_rd, hz.wb_reg_write);
    assign hz.fwd_b = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write,
                              hz.wb_rd, hz.wb_reg_write);

    // A frozen cycle keeps ID/EX as is, so no bubble and no flush then.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.ex_mem_write = 1'b1;
        hz.mem_wb_write = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        priority case (1'b1)
            mem_stall: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.ex_mem_write = 1'b0;
                hz.mem_wb_write = 1'b0;
            end
            (state == LU_STALL): begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
            hz.ex_branch_taken: begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end
            load_use: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            lu_left <= 3'd0;
        end else if (!mem_stall) begin
            unique case (state)
                RUN: begin
                    if (!hz.ex_branch_taken && load_use && MULTI_BUBBLE) begin
                        state   <= LU_STALL;
                        lu_left <= LU_INIT;
                    end
                end
                LU_STALL: begin
                    if (lu_left <= 3'd1) begin
                        state   <= RUN;
                        lu_left <= 3'd0;
                    end else begin
                        lu_left <= lu_left - 3'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    lu_left <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!hz.pc_write && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (hz.if_id_flush && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus random traffic
// against a bubble-count reference model, on 1-bubble and 3-bubble builds.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic mem_reg_write, wb_reg_write, mem_req, mem_ready;

    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) if1 ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(5))  if3 ();

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(16))
        u1 (.clk(clk), .rst(rst), .hz(if1));
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .CNT_W(5))
        u3 (.clk(clk), .rst(rst), .hz(if3));

    assign if1.id_rs1 = id_rs1;           assign if3.id_rs1 = id_rs1;
    assign if1.id_rs2 = id_rs2;           assign if3.id_rs2 = id_rs2;
    assign if1.id_uses_rs1 = id_uses_rs1; assign if3.id_uses_rs1 = id_uses_rs1;
    assign if1.id_uses_rs2 = id_uses_rs2; assign if3.id_uses_rs2 = id_uses_rs2;
    assign if1.ex_rs1 = ex_rs1;           assign if3.ex_rs1 = ex_rs1;
    assign if1.ex_rs2 = ex_rs2;           assign if3.ex_rs2 = ex_rs2;
    assign if1.ex_rd = ex_rd;             assign if3.ex_rd = ex_rd;
    assign if1.ex_mem_read = ex_mem_read; assign if3.ex_mem_read = ex_mem_read;
    assign if1.ex_branch_taken = ex_branch_taken;
    assign if3.ex_branch_taken = ex_branch_taken;
    assign if1.mem_rd = mem_rd;           assign if3.mem_rd = mem_rd;
    assign if1.wb_rd = wb_rd;             assign if3.wb_rd = wb_rd;
    assign if1.mem_reg_write = mem_reg_write;
    assign if3.mem_reg_write = mem_reg_write;
    assign if1.wb_reg_write = wb_reg_write;
    assign if3.wb_reg_write = wb_reg_write;
    assign if1.mem_req = mem_req;         assign if3.mem_req = mem_req;
    assign if1.mem_ready = mem_ready;     assign if3.mem_ready = mem_ready;

    logic [9:0]  ctl [2];
    logic [31:0] sc  [2];
    logic [31:0] fc  [2];

    assign ctl[0] = {if1.pc_write, if1.if_id_write, if1.ex_mem_write,
                     if1.mem_wb_write, if1.if_id_flush, if1.id_ex_bubble,
                     if1.fwd_a, if1.fwd_b};
    assign ctl[1] = {if3.pc_write, if3.if_id_write, if3.ex_mem_write,
                     if3.mem_wb_write, if3.if_id_flush, if3.id_ex_bubble,
                     if3.fwd_a, if3.fwd_b};
    assign sc[0] = 32'(if1.stall_cnt);
    assign sc[1] = 32'(if3.stall_cnt);
    assign fc[0] = 32'(if1.flush_cnt);
    assign fc[1] = 32'(if3.flush_cnt);

    int checks   = 0;
    int failures = 0;

    int n_bub [2] = '{1, 3};
    int c_max [2] = '{65535, 31};
    int rem   [2];
    int m_sc  [2];
    int m_fc  [2];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0;
        mem_reg_write = 0; wb_reg_write = 0;
        mem_req = 0; mem_ready = 1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic tick();
        bit ms, lu, pc, ifw, exw, mww, fl, bub;
        #1;
        ms = mem_req && !mem_ready;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && ex_rd == id_rs1) ||
              (id_uses_rs2 && ex_rd == id_rs2));
        for (int i = 0; i < 2; i++) begin
            pc = 1; ifw = 1; exw = 1; mww = 1; fl = 0; bub = 0;
            if (ms) begin
                pc = 0; ifw = 0; exw = 0; mww = 0;
            end else if (rem[i] > 0) begin
                pc = 0; ifw = 0; bub = 1;
                rem[i]--;
            end else if (ex_branch_taken) begin
                fl = 1; bub = 1;
            end else if (lu) begin
                pc = 0; ifw = 0; bub = 1;
                rem[i] = n_bub[i] - 1;
            end
            check($sformatf("ctl%0d", i), {22'd0, ctl[i]},
                  {22'd0, pc, ifw, exw, mww, fl, bub,
                   ref_fwd(ex_rs1), ref_fwd(ex_rs2)});
            check($sformatf("stall_cnt%0d", i), sc[i], m_sc[i]);
            check($sformatf("flush_cnt%0d", i), fc[i], m_fc[i]);
            if (!pc && m_sc[i] < c_max[i]) m_sc[i]++;
            if (fl && m_fc[i] < c_max[i]) m_fc[i]++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            check($sformatf("rst_ctl%0d", i), {22'd0, ctl[i]},
                  {22'd0, 10'b1111_00_00_00});
            check($sformatf("rst_sc%0d", i), sc[i], 0);
            check($sformatf("rst_fc%0d", i), fc[i], 0);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic hazard();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        id_rs2 = 1; id_uses_rs2 = 1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();
        tick();

        hazard(); tick();
        idle(); repeat (4) tick();
        check("lu_n1_stall", sc[0], 1);
        check("lu_n3_stall", sc[1], 3);

        do_reset();
        hazard(); tick();
        idle(); tick();
        mem_req = 1; mem_ready = 0; repeat (2) tick();
        idle(); repeat (4) tick();
        check("lu_ms_n1", sc[0], 3);
        check("lu_ms_n3", sc[1], 5);

        do_reset();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; tick();
        idle();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 1;
        id_uses_rs1 = 1; id_uses_rs2 = 0; tick();
        check("no_hazard_sc", sc[1], 0);

        do_reset();
        hazard(); ex_branch_taken = 1; tick();
        idle(); tick();
        check("br_lu_fc", fc[1], 1);
        check("br_lu_sc", sc[1], 0);

        do_reset();
        ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
        repeat (4) tick();
        check("br_defer_fc", fc[0], 0);
        mem_ready = 1; tick();
        idle(); tick();
        check("br_after_fc", fc[0], 1);
        check("br_after_sc", sc[0], 4);

        ex_rs1 = 7; mem_rd = 7; wb_rd = 7;
        mem_reg_write = 1; wb_reg_write = 1;
        #1 check("fwd_mem", {30'd0, ctl[0][3:2]}, 2);
        tick();
        mem_reg_write = 0;
        #1 check("fwd_wb", {30'd0, ctl[0][3:2]}, 1);
        tick();
        idle();

        do_reset();
        mem_req = 1; mem_ready = 0; repeat (40) tick();
        check("sat_n3", sc[1], 31);
        check("nosat_n1", sc[0], 40);
        idle(); tick();

        do_reset();
        hazard(); tick();
        do_reset();
        tick();

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                id_rs1 = 5'($urandom_range(0, 3));
                id_rs2 = 5'($urandom_range(0, 3));
                ex_rs1 = 5'($urandom_range(0, 3));
                ex_rs2 = 5'($urandom_range(0, 3));
                ex_rd  = 5'($urandom_range(0, 3));
                mem_rd = 5'($urandom_range(0, 3));
                wb_rd  = 5'($urandom_range(0, 3));
                id_uses_rs1 = 1'($urandom);
                id_uses_rs2 = 1'($urandom);
                ex_mem_read = 1'($urandom);
                ex_branch_taken = ($urandom_range(0, 5) == 0);
                mem_reg_write = 1'($urandom);
                wb_reg_write  = 1'($urandom);
                mem_req   = 1'($urandom);
                mem_ready = ($urandom_range(0, 9) < 7);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
